// File: rtl/matrix_pkg.sv
// Shared constants and types for the 8x8 RGB matrix row feeder.
package matrix_pkg;

    localparam int unsigned MATRIX_ROWS = 8;
    localparam int unsigned MATRIX_COLS = 8;
    localparam int unsigned ROW_W       = $clog2(MATRIX_ROWS);
    localparam int unsigned COL_W       = $clog2(MATRIX_COLS);
    localparam int unsigned ADDR_W      = ROW_W + COL_W;
    localparam int unsigned WORD_W      = 32;

    // row_word field positions; red leaves the shifter first
    localparam int unsigned RED_HI   = 31;
    localparam int unsigned RED_LO   = 24;
    localparam int unsigned BLUE_HI  = 23;
    localparam int unsigned BLUE_LO  = 16;
    localparam int unsigned GREEN_HI = 15;
    localparam int unsigned GREEN_LO = 8;
    localparam int unsigned ANODE_HI = 7;
    localparam int unsigned ANODE_LO = 0;

    // All colours dark (active-low), no anode driven
    localparam logic [WORD_W-1:0] RESET_WORD = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        IDLE,
        BUILD,
        PRESENT
    } state_t;

endpackage

// File: rtl/matrix_row_feeder_if.sv
// Host write / swap / row-stream bundle between the pixel source and its neighbours.
interface matrix_row_feeder_if
    import matrix_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) ();

    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [3*PWM_BITS-1:0]   wr_rgb;
    logic                    swap_req;
    logic                    swap_done;
    logic [WORD_W-1:0]       row_word;
    logic                    row_valid;
    logic                    row_ready;
    logic                    frame_start;

    modport master (
        output wr_en, wr_addr, wr_rgb, swap_req, row_ready,
        input  swap_done, row_word, row_valid, frame_start
    );

    modport slave (
        input  wr_en, wr_addr, wr_rgb, swap_req, row_ready,
        output swap_done, row_word, row_valid, frame_start
    );

endinterface

// File: rtl/matrix_frame_ram.sv
// Double-banked 64-pixel frame store: one write port, one synchronous read port.
module matrix_frame_ram
    import matrix_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [3*PWM_BITS-1:0] wr_data,
    input  logic                  rd_bank,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [3*PWM_BITS-1:0] rd_data
);

    localparam int unsigned DATA_W = 3 * PWM_BITS;
    localparam int unsigned DEPTH  = 2 * (1 << ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/matrix_row_feeder.sv
// PWM row sequencer: builds one active-low colour row word per handshake from the
// front bank of a double-buffered frame, swapping banks only at frame boundaries.
module matrix_row_feeder
    import matrix_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic          clk_25mhz,
    input  logic          reset,
    matrix_row_feeder_if.slave bus
);

    localparam int unsigned NPH    = (1 << PWM_BITS) - 1;
    localparam int unsigned RGB_W  = 3 * PWM_BITS;
    localparam int unsigned STEP_W = COL_W + 1;
    localparam logic [PWM_BITS-1:0] LAST_PHASE = PWM_BITS'(NPH - 1);
    localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(MATRIX_ROWS - 1);
    localparam logic [STEP_W-1:0]   LAST_STEP  = STEP_W'(MATRIX_COLS);

    state_t                 state;
    logic                   front;
    logic                   pending;
    logic [PWM_BITS-1:0]    phase;
    logic [ROW_W-1:0]       row;
    logic [STEP_W-1:0]      step;
    logic [MATRIX_COLS-2:0] red_off;
    logic [MATRIX_COLS-2:0] grn_off;
    logic [MATRIX_COLS-2:0] blu_off;
    logic [WORD_W-1:0]      row_word;
    logic                   row_valid;
    logic                   frame_start;
    logic                   swap_done;
    logic [RGB_W-1:0]       rd_data;

    logic [ADDR_W-1:0]      rd_addr_c;
    logic                   red_off_c;
    logic                   grn_off_c;
    logic                   blu_off_c;
    logic                   xfer_c;
    logic                   last_word_c;
    logic [WORD_W-1:0]      word_c;

    matrix_frame_ram #(
        .PWM_BITS (PWM_BITS)
    ) u_ram (
        .clk     (clk_25mhz),
        .wr_en   (bus.wr_en),
        .wr_bank (~front),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_rgb),
        .rd_bank (front),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    // Step k addresses column k; data for column k-1 returns the same cycle
    always_comb begin
        rd_addr_c   = {row, step[COL_W-1:0]};
        red_off_c   = !(rd_data[RGB_W-1 -: PWM_BITS] > phase);
        grn_off_c   = !(rd_data[2*PWM_BITS-1 -: PWM_BITS] > phase);
        blu_off_c   = !(rd_data[PWM_BITS-1:0] > phase);
        xfer_c      = (state == PRESENT) && row_valid && bus.row_ready;
        last_word_c = (phase == LAST_PHASE) && (row == LAST_ROW);
        word_c                     = RESET_WORD;
        word_c[RED_HI:RED_LO]      = {red_off_c, red_off};
        word_c[BLUE_HI:BLUE_LO]    = {blu_off_c, blu_off};
        word_c[GREEN_HI:GREEN_LO]  = {grn_off_c, grn_off};
        word_c[ANODE_HI:ANODE_LO]  = 8'(1) << row;
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state       <= IDLE;
            front       <= 1'b0;
            pending     <= 1'b0;
            phase       <= '0;
            row         <= '0;
            step        <= '0;
            red_off     <= '1;
            grn_off     <= '1;
            blu_off     <= '1;
            row_word    <= RESET_WORD;
            row_valid   <= 1'b0;
            frame_start <= 1'b0;
            swap_done   <= 1'b0;
        end else begin
            swap_done <= 1'b0;

            // A request arriving with the last transfer still catches this boundary
            if (xfer_c && last_word_c && (pending || bus.swap_req)) begin
                front     <= ~front;
                pending   <= 1'b0;
                swap_done <= 1'b1;
            end else if (bus.swap_req) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    step  <= '0;
                    state <= BUILD;
                end
                BUILD: begin
                    if ((step != '0) && (step != LAST_STEP)) begin
                        red_off[COL_W'(step - 1'b1)] <= red_off_c;
                        grn_off[COL_W'(step - 1'b1)] <= grn_off_c;
                        blu_off[COL_W'(step - 1'b1)] <= blu_off_c;
                    end
                    if (step == LAST_STEP) begin
                        row_word    <= word_c;
                        row_valid   <= 1'b1;
                        frame_start <= (phase == '0) && (row == '0);
                        step        <= '0;
                        state       <= PRESENT;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                PRESENT: begin
                    if (xfer_c) begin
                        row_valid   <= 1'b0;
                        frame_start <= 1'b0;
                        state       <= BUILD;
                        if (row == LAST_ROW) begin
                            row   <= '0;
                            phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.row_word    = row_word;
    assign bus.row_valid   = row_valid;
    assign bus.frame_start = frame_start;
    assign bus.swap_done   = swap_done;

endmodule

// File: tb/tb_matrix_row_feeder.sv
// Randomised scoreboard bench for matrix_row_feeder against a frame-level reference model.
module tb_matrix_row_feeder;
    import matrix_pkg::*;

    localparam int unsigned PWM_BITS = 4;
    localparam int NPH         = 15;
    localparam int FRAME_WORDS = 8 * NPH;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] mask;
        logic        fs;
    } exp_t;

    logic clk_25mhz = 1'b0;
    logic reset;
    always #20 clk_25mhz = ~clk_25mhz;

    matrix_row_feeder_if #(.PWM_BITS(PWM_BITS)) bus ();

    matrix_row_feeder #(.PWM_BITS(PWM_BITS)) dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: two banks of pixel levels, which bank is shown, and the word index
    logic [11:0] mbank  [2][64];
    bit          mknown [2][64];
    int          mfront = 0;
    bit          mpend  = 0;
    int          widx   = 0;
    exp_t        sb_q[$];

    bit rst_prev = 0, started = 0, swap_exp = 0, hold_pend = 0, prev_xfer = 0;
    bit first_pend = 0, gap_armed = 0;
    int rel_cnt = 0, gap_cnt = 0, swap_cnt = 0;
    int win_arm = 0, win_kind = 0, win_words = 0, win_hits = 0, win_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Word for index idx: phase idx/8, row idx%8; a colour is lit in phases 0..level-1
    function automatic exp_t expect_word(input int idx);
        exp_t        e;
        int          ph, r, a;
        logic [11:0] lv;
        ph = idx / 8;
        r  = idx % 8;
        e.word = 32'hFFFF_FF00;
        e.mask = 32'h0000_00FF;
        e.word[7:0] = 8'(1 << r);
        for (int c = 0; c < 8; c++) begin
            a  = r * 8 + c;
            lv = mbank[mfront][a];
            if (mknown[mfront][a]) begin
                e.word[24 + c] = !(int'(lv[11:8]) > ph);
                e.word[8 + c]  = !(int'(lv[7:4])  > ph);
                e.word[16 + c] = !(int'(lv[3:0])  > ph);
                e.mask[24 + c] = 1'b1;
                e.mask[16 + c] = 1'b1;
                e.mask[8 + c]  = 1'b1;
            end
        end
        e.fs = (idx == 0);
        return e;
    endfunction

    // Monitor + model step: outputs and this cycle's inputs are sampled mid-cycle
    always @(negedge clk_25mhz) begin
        exp_t e;
        bit   xfer, swap_n;
        if (rst_prev) begin
            check("reset_row_valid", 32'(bus.row_valid), 32'd0);
            check("reset_row_word", bus.row_word, 32'hFFFF_FF00);
            check("reset_swap_done", 32'(bus.swap_done), 32'd0);
            check("reset_frame_start", 32'(bus.frame_start), 32'd0);
            rel_cnt = 0;
        end else if (started) begin
            rel_cnt++;
            check("swap_done", 32'(bus.swap_done), 32'(swap_exp));
            if (bus.swap_done) begin
                swap_cnt++;
                if (win_arm != 0) begin
                    win_kind = win_arm; win_arm = 0; win_words = 0; win_hits = 0;
                end
            end
            if (prev_xfer) check("valid_drop_after_xfer", 32'(bus.row_valid), 32'd0);
            if (hold_pend && sb_q.size() > 0) begin
                e = sb_q[0];
                check("hold_row_valid", 32'(bus.row_valid), 32'd1);
                check("hold_row_word", bus.row_word & e.mask, e.word & e.mask);
                check("hold_frame_start", 32'(bus.frame_start), 32'(e.fs));
            end
            if (gap_armed) gap_cnt++;
            if (bus.row_valid && first_pend) begin
                check_range("first_valid_latency", rel_cnt, 1, 11);
                first_pend = 0;
            end
            if (bus.row_valid && gap_armed) begin
                check_range("row_spacing", gap_cnt, 10, 11);
                gap_armed = 0;
            end else if (gap_armed && gap_cnt > 40) begin
                check_range("row_spacing_timeout", gap_cnt, 10, 11);
                gap_armed = 0;
            end
            if (bus.row_valid && bus.row_ready) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("row_word", bus.row_word & e.mask, e.word & e.mask);
                    check("frame_start", 32'(bus.frame_start), 32'(e.fs));
                end
                if (win_kind != 0) begin
                    win_words++;
                    if (win_kind == 2 && bus.row_word[31:8] == 24'hDF_FFFF && bus.row_word[7:0] == 8'h04)
                        win_hits++;
                    if (win_kind == 3 && bus.row_word[24] == 1'b0)
                        win_hits++;
                    if (win_words == FRAME_WORDS) begin
                        check_range(win_kind == 2 ? "red_r2c5_words" : "red_level1_words",
                                    win_hits, win_kind == 2 ? 15 : 1, win_kind == 2 ? 15 : 1);
                        win_kind = 0;
                        win_done++;
                    end
                end
            end
        end

        swap_n = 0;
        prev_xfer = 0;
        if (reset) begin
            mfront = 0; mpend = 0; widx = 0;
            sb_q.delete();
            sb_q.push_back(expect_word(0));
            hold_pend = 0; gap_armed = 0; first_pend = 1; started = 1;
            win_kind = 0;
        end else if (started) begin
            xfer = bus.row_valid && bus.row_ready;
            if (bus.wr_en) begin
                mbank[1 - mfront][bus.wr_addr]  = bus.wr_rgb;
                mknown[1 - mfront][bus.wr_addr] = 1'b1;
            end
            if (xfer && widx == FRAME_WORDS - 1 && (mpend || bus.swap_req)) begin
                mfront = 1 - mfront; mpend = 0; swap_n = 1;
            end else if (bus.swap_req) begin
                mpend = 1;
            end
            if (xfer) begin
                widx = (widx + 1) % FRAME_WORDS;
                sb_q.push_back(expect_word(widx));
                gap_armed = 1; gap_cnt = 0; prev_xfer = 1;
            end
            hold_pend = bus.row_valid && !bus.row_ready;
        end
        swap_exp = swap_n;
        rst_prev = reset;
    end

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic write_px(input int a, input logic [11:0] rgb);
        bus.wr_en = 1'b1; bus.wr_addr = 6'(a); bus.wr_rgb = rgb;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
    endtask

    // kind 0: random, 1: only (r2,c5)=R15, 2: only (r0,c0) red level 1
    task automatic fill(input int kind);
        logic [11:0] v;
        for (int a = 0; a < 64; a++) begin
            v = 12'h000;
            if (kind == 0) v = 12'($urandom);
            if (kind == 1 && a == 21) v = 12'hF00;
            if (kind == 2 && a == 0) v = 12'h100;
            write_px(a, v);
        end
    endtask

    task automatic wait_swap_done(input string name);
        int n = 0;
        while (!bus.swap_done && n < 4000) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (n >= 4000) check(name, 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_win(input string name);
        int d0 = win_done;
        int n = 0;
        while (win_done == d0 && n < 6000) begin
            tick();
            n++;
        end
        if (n >= 6000) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.row_valid && n < 100) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (n >= 100) check(name, 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int sc0, n;
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_rgb = '0;
        bus.swap_req = 1'b0; bus.row_ready = 1'b1;
        repeat (4) tick();
        reset = 1'b0;

        // Populate both banks so every later word is fully predictable
        fill(0); pulse_swap(); wait_swap_done("init_swap1_timeout");
        fill(0); pulse_swap(); wait_swap_done("init_swap2_timeout");

        win_arm = 2; fill(1); pulse_swap(); wait_win("red_r2c5_timeout");
        win_arm = 3; fill(2); pulse_swap(); wait_win("red_level1_timeout");

        // Backpressure: hold the presented word for 20 cycles
        bus.row_ready = 1'b0;
        wait_valid("bp_valid_timeout");
        repeat (20) tick();
        bus.row_ready = 1'b1;
        repeat (30) tick();

        // Two merged swap requests mid-frame with writes in between
        n = 0;
        while (widx != 40 && n < 3000) begin tick(); n++; end
        sc0 = swap_cnt;
        pulse_swap();
        for (int i = 0; i < 20; i++) write_px(int'($urandom_range(63)), 12'($urandom));
        pulse_swap();
        for (int i = 0; i < 20; i++) write_px(int'($urandom_range(63)), 12'($urandom));
        wait_swap_done("merged_swap_timeout");
        for (int i = 0; i < 1300; i++) begin
            bus.wr_en = ($urandom_range(2) == 0);
            bus.wr_addr = 6'($urandom); bus.wr_rgb = 12'($urandom);
            tick();
        end
        bus.wr_en = 1'b0;
        check_range("merged_swap_count", swap_cnt - sc0, 1, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.row_ready = ($urandom_range(3) != 0);
            bus.wr_en = ($urandom_range(2) == 0);
            bus.wr_addr = 6'($urandom); bus.wr_rgb = 12'($urandom);
            bus.swap_req = ($urandom_range(149) == 0);
            tick();
        end
        bus.wr_en = 1'b0; bus.swap_req = 1'b0;

        // Reset while a word is stalled in PRESENT
        bus.row_ready = 1'b0;
        wait_valid("pre_reset_valid_timeout");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.row_ready = 1'b1;
        repeat (300) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
